// File: rtl/comp_operand_in_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comp_operand_in_pkg                                                  |
// | Shared constants and helpers for the comparator operand input stage. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package comp_operand_in_pkg;

  localparam int   DB_CYCLES_DEFAULT = 240000;
  localparam int   CLK_HZ            = 12_000_000;
  localparam logic KEY_IDLE          = 1'b1;

  // Bits needed to hold the values 0..value-1; at least 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comp_operand_in_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comp_operand_in_if                                                   |
// | Raw board inputs in, conditioned comparator operands out.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface comp_operand_in_if #(
  parameter int N = 4
);

  logic [N-1:0] sw;
  logic [N-1:0] key_n;
  logic [N-1:0] x_q;
  logic [N-1:0] y_q;
  logic         upd;

  modport master (
    output sw,
    output key_n,
    input  x_q,
    input  y_q,
    input  upd
  );

  modport slave (
    input  sw,
    input  key_n,
    output x_q,
    output y_q,
    output upd
  );

endinterface
`default_nettype wire

// File: rtl/comp_operand_in_debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_ch                                                          |
// | One-bit 2-flop synchronizer followed by a counting debouncer.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module debounce_ch
  import comp_operand_in_pkg::*;
#(
  parameter int   DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter logic RST_VAL   = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_raw,
  output logic      o_stable
);

  localparam int             c_CNT_W = clog2(DB_CYCLES);
  localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(DB_CYCLES - 1);

  logic               r_meta;
  logic               r_sync;
  logic               r_stable;
  logic [c_CNT_W-1:0] r_cnt;

  // Any return to the stable level restarts the count, so only an
  // uninterrupted run of DB_CYCLES differing samples is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= RST_VAL;
      r_sync   <= RST_VAL;
      r_stable <= RST_VAL;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_TERM) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/comp_operand_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comp_operand_in                                                      |
// | Debounced switch operand x and key-toggled operand y, with upd pulse.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module comp_operand_in
  import comp_operand_in_pkg::*;
#(
  parameter int N         = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  comp_operand_in_if.slave bus
);

  logic [N-1:0] w_sw_stable;
  logic [N-1:0] w_key_stable;
  logic [N-1:0] w_press;
  logic [N-1:0] w_x_next;
  logic [N-1:0] w_y_next;
  logic         w_chg;

  logic [N-1:0] r_key_stable_d;
  logic [N-1:0] r_x_q;
  logic [N-1:0] r_y_q;
  logic         r_chg;
  logic         r_upd;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_ch
      debounce_ch #(
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (1'b0)
      ) u_sw (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raw    (bus.sw[gi]),
        .o_stable (w_sw_stable[gi])
      );

      debounce_ch #(
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (KEY_IDLE)
      ) u_key (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raw    (bus.key_n[gi]),
        .o_stable (w_key_stable[gi])
      );
    end
  endgenerate

  // Keys are active-low: a press is a debounced high-to-low transition.
  assign w_press  = r_key_stable_d & ~w_key_stable;
  assign w_x_next = w_sw_stable;
  assign w_y_next = r_y_q ^ w_press;
  assign w_chg    = (w_x_next != r_x_q) | (|w_press);

  // r_chg marks the edge where an operand changes; upd follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_stable_d <= {N{KEY_IDLE}};
      r_x_q          <= '0;
      r_y_q          <= '0;
      r_chg          <= 1'b0;
      r_upd          <= 1'b0;
    end else begin
      r_key_stable_d <= w_key_stable;
      r_x_q          <= w_x_next;
      r_y_q          <= w_y_next;
      r_chg          <= w_chg;
      r_upd          <= r_chg;
    end
  end

  assign bus.x_q = r_x_q;
  assign bus.y_q = r_y_q;
  assign bus.upd = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_comp_operand_in.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_comp_operand_in                                                   |
// | Directed scenarios plus random pin activity against a sample model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_comp_operand_in;
  import comp_operand_in_pkg::*;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int NC = 2 * N;
  localparam logic [NC-1:0] c_RST = {{N{1'b1}}, {N{1'b0}}};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  comp_operand_in_if #(.N(N)) bus ();

  comp_operand_in #(
    .N         (N),
    .DB_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total    = 0;
  int bad      = 0;
  int upd_seen = 0;
  bit chk_en   = 1'b0;

  // Model: channel c is sw[c] for c<N, key_n[c-N] otherwise. A channel's
  // level flips once it has seen DB consecutive synchronized samples that
  // all disagree with it since its last flip.
  logic [NC-1:0] m_s1, m_s2, m_st;
  bit            hq [NC][$];
  logic [N-1:0]  m_x, m_y, m_fell, t_nx, t_ny;
  logic          m_upd, m_chg;
  bit            t_all;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = c_RST; m_s2 = c_RST; m_st = c_RST;
      for (int c = 0; c < NC; c++) hq[c].delete();
      m_x = '0; m_y = '0; m_fell = '0; m_upd = 1'b0; m_chg = 1'b0;
    end else begin
      t_nx  = m_st[N-1:0];
      t_ny  = m_y ^ m_fell;
      m_upd = m_chg;
      m_chg = (t_nx != m_x) || (t_ny != m_y);
      m_x   = t_nx;
      m_y   = t_ny;
      m_fell = '0;
      for (int c = 0; c < NC; c++) begin
        hq[c].push_back(m_s2[c]);
        if (hq[c].size() > DB) void'(hq[c].pop_front());
        if (hq[c].size() == DB) begin
          t_all = 1'b1;
          for (int k = 0; k < DB; k++) if (hq[c][k] == m_st[c]) t_all = 1'b0;
          if (t_all) begin
            m_st[c] = ~m_st[c];
            hq[c].delete();
            if (c >= N && m_st[c] == 1'b0) m_fell[c-N] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {bus.key_n, bus.sw};
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      chk("x_q", {28'd0, bus.x_q}, {28'd0, m_x});
      chk("y_q", {28'd0, bus.y_q}, {28'd0, m_y});
      chk("upd", {31'd0, bus.upd}, {31'd0, m_upd});
      if (bus.upd) upd_seen++;
    end
  end

  task automatic set_pins(input logic [N-1:0] s, input logic [N-1:0] k);
    @(negedge clk);
    bus.sw    = s;
    bus.key_n = k;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sw    = 4'b1010;
    bus.key_n = 4'hF;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_x", {28'd0, bus.x_q}, 32'h0);
    chk("rst_y", {28'd0, bus.y_q}, 32'h0);
    chk("rst_upd", {31'd0, bus.upd}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    step(10);
    chk("rst_x_c10", {28'd0, bus.x_q}, 32'h0);
    step(1);
    chk("rst_x_c11", {28'd0, bus.x_q}, 32'hA);
    chk("model_x_c11", {28'd0, m_x}, 32'hA);
    step(1);
    chk("rst_upd_c12", {31'd0, bus.upd}, 32'h1);

    // Clean press of key 2, then a second press.
    set_pins(4'b1010, 4'b1011);
    step(10);
    chk("press_y_c10", {28'd0, bus.y_q}, 32'h0);
    step(1);
    chk("press_y_c11", {28'd0, bus.y_q}, 32'h4);
    chk("model_y_c11", {28'd0, m_y}, 32'h4);
    step(1);
    chk("press_upd", {31'd0, bus.upd}, 32'h1);
    step(8);
    set_pins(4'b1010, 4'hF);
    step(20);
    chk("release_y", {28'd0, bus.y_q}, 32'h4);
    set_pins(4'b1010, 4'b1011);
    step(11);
    chk("press2_y", {28'd0, bus.y_q}, 32'h0);
    step(9);
    set_pins(4'b1010, 4'hF);
    step(20);

    // Bouncing key 0 must never be accepted.
    upd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.key_n = {3'b111, logic'(i % 2)};
      repeat (2) @(negedge clk);
    end
    bus.key_n = 4'hF;
    step(20);
    chk("bounce_y", {28'd0, bus.y_q}, 32'h0);
    chk("bounce_upd_cnt", upd_seen, 32'd0);

    // All keys at once.
    upd_seen = 0;
    set_pins(4'b1010, 4'h0);
    step(10);
    chk("all_y_c10", {28'd0, bus.y_q}, 32'h0);
    step(1);
    chk("all_y_c11", {28'd0, bus.y_q}, 32'hF);
    step(20);
    chk("all_upd_cnt", upd_seen, 32'd1);
    set_pins(4'b1010, 4'hF);
    step(20);
    set_pins(4'b1010, 4'h0);
    step(11);
    chk("all2_y", {28'd0, bus.y_q}, 32'h0);
    step(9);
    set_pins(4'b1010, 4'hF);
    step(20);

    // Switch change and key 3 press on the same cycle.
    set_pins(4'h0, 4'hF);
    step(20);
    upd_seen = 0;
    set_pins(4'h5, 4'b0111);
    step(10);
    chk("mix_x_c10", {28'd0, bus.x_q}, 32'h0);
    step(1);
    chk("mix_x_c11", {28'd0, bus.x_q}, 32'h5);
    chk("mix_y_c11", {28'd0, bus.y_q}, 32'h8);
    step(20);
    chk("mix_upd_cnt", upd_seen, 32'd1);
    set_pins(4'h5, 4'hF);
    step(20);

    // Reset while key 1 is part-way through debouncing.
    set_pins(4'h5, 4'b1101);
    step(5);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_y", {28'd0, bus.y_q}, 32'h0);
    chk("rstmid_x", {28'd0, bus.x_q}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(11);
    chk("rstmid_y_c11", {28'd0, bus.y_q}, 32'h2);
    chk("rstmid_x_c11", {28'd0, bus.x_q}, 32'h5);
    step(20);

    // Random pin activity with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
      end else begin
        set_pins(N'($urandom), N'($urandom));
        repeat ($urandom_range(1, 14)) @(posedge clk);
      end
    end
    set_pins(4'h0, 4'hF);
    step(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
